// File: rtl/noc_merge_arbiter.sv
// N-to-1 merge of upstream packet FIFOs into a source-tagged FWFT queue.
// Build option MERGE_RR_EN: round-robin channel selection (default: fixed priority, lowest index).
module noc_merge_arbiter #(
    parameter int N_IN  = 20,
    parameter int PKT_W = 36,
    parameter int DEPTH = 16,
    parameter int SEL_W = $clog2(N_IN)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_IN-1:0]          in_empty,
    input  logic [N_IN*PKT_W-1:0]    in_packet,
    output logic [N_IN-1:0]          in_read_req,
    input  logic [N_IN-1:0]          in_read_gnt,
    input  logic                     out_read_req,
    output logic                     out_read_gnt,
    output logic                     out_empty,
    output logic                     out_full,
    output logic [PKT_W-1:0]         out_packet,
    output logic [SEL_W-1:0]         out_src,
    output logic [$clog2(DEPTH):0]   out_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = SEL_W + PKT_W;

    typedef enum logic [1:0] {IDLE, REQ, CAP} state_t;

    state_t            state, state_nxt;
    logic [SEL_W-1:0]  sel, sel_nxt, pick_idx, rr_ptr;
    logic [N_IN-1:0]   req_nxt;
    logic              admit, pop, wr_en;
    logic [ENT_W-1:0]  wdata, head_nxt;
    logic [ENT_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr, rd_nxt;
    logic [CNT_W-1:0]  count, count_nxt;

    // First available channel at or above start, wrapping past N_IN-1.
    function automatic logic [SEL_W-1:0] pick(input logic [N_IN-1:0] avail,
                                              input logic [SEL_W-1:0] start);
        logic found;
        int   idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < N_IN; k++) begin
            idx = int'(start) + k;
            if (idx >= N_IN) idx = idx - N_IN;
            if (!found && avail[idx]) begin
                pick  = SEL_W'(idx);
                found = 1'b1;
            end
        end
    endfunction

    assign pop          = out_read_req && (count != '0);
    assign out_read_gnt = pop;
    assign out_empty    = (count == '0);
    assign out_full     = (count == CNT_W'(DEPTH));
    assign out_count    = count;

    // Admission looks at occupancy after this cycle's pop; one packet in flight at most.
    assign admit    = (|(~in_empty)) && ((count != CNT_W'(DEPTH)) || pop);
    assign pick_idx = pick(~in_empty, rr_ptr);
    assign wdata    = {sel, in_packet[sel*PKT_W +: PKT_W]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            sel         <= '0;
            in_read_req <= '0;
        end else begin
            state       <= state_nxt;
            sel         <= sel_nxt;
            in_read_req <= req_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (admit) state_nxt = REQ;
            REQ: begin
                if (in_read_gnt[sel])   state_nxt = CAP;
                else if (in_empty[sel]) state_nxt = IDLE;
            end
            CAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_nxt = '0;
        sel_nxt = sel;
        wr_en   = 1'b0;
        case (state)
            IDLE: begin
                if (admit) begin
                    sel_nxt = pick_idx;
                    req_nxt = N_IN'(1) << pick_idx;
                end
            end
            REQ: begin
                if (!in_read_gnt[sel] && !in_empty[sel]) req_nxt = in_read_req;
            end
            CAP:     wr_en = 1'b1;
            default: ;
        endcase
    end

`ifdef MERGE_RR_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)       rr_ptr <= '0;
        else if (wr_en) rr_ptr <= (sel == SEL_W'(N_IN - 1)) ? '0 : sel + 1'b1;
    end
`else
    assign rr_ptr = '0;
`endif

    // Queue: head is registered so out_packet holds when empty and appears the cycle after CAP.
    assign rd_nxt    = rd_ptr + PTR_W'(pop);
    assign count_nxt = count + CNT_W'(wr_en) - CNT_W'(pop);
    assign head_nxt  = (wr_en && (wr_ptr == rd_nxt)) ? wdata : mem[rd_nxt];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            out_packet <= '0;
            out_src    <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(wr_en);
            rd_ptr <= rd_nxt;
            count  <= count_nxt;
            if (count_nxt != '0) {out_src, out_packet} <= head_nxt;
        end
    end

endmodule

// File: tb/tb_noc_merge_arbiter.sv
// Bench for noc_merge_arbiter: upstream FIFO model, scoreboard of captured packets, directed corner cases.
module tb_noc_merge_arbiter;

    localparam int N_IN  = 20;
    localparam int PKT_W = 36;
    localparam int DEPTH = 16;
    localparam int SEL_W = 5;
    localparam int CNT_W = 5;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [N_IN-1:0]       in_empty;
    logic [N_IN*PKT_W-1:0] in_packet;
    logic [N_IN-1:0]       in_read_req;
    logic [N_IN-1:0]       in_read_gnt;
    logic                  out_read_req;
    logic                  out_read_gnt;
    logic                  out_empty;
    logic                  out_full;
    logic [PKT_W-1:0]      out_packet;
    logic [SEL_W-1:0]      out_src;
    logic [CNT_W-1:0]      out_count;

    always #5 clk = ~clk;

    noc_merge_arbiter #(.N_IN(N_IN), .PKT_W(PKT_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_empty(in_empty), .in_packet(in_packet),
        .in_read_req(in_read_req), .in_read_gnt(in_read_gnt),
        .out_read_req(out_read_req), .out_read_gnt(out_read_gnt),
        .out_empty(out_empty), .out_full(out_full),
        .out_packet(out_packet), .out_src(out_src), .out_count(out_count)
    );

    logic [PKT_W-1:0]       up_q [N_IN][$];
    logic [SEL_W+PKT_W-1:0] sb [$];
    int                     order [$];
    logic [N_IN-1:0]        gnt_en;
    logic                   cap_now;
    int                     errors = 0;
    int                     checks = 0;

    typedef struct {
        int              ch;
        logic [PKT_W-1:0] pkt;
        logic [N_IN-1:0] exp_req;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic refresh();
        for (int i = 0; i < N_IN; i++) in_empty[i] = (up_q[i].size() == 0);
        in_read_gnt = in_read_req & ~in_empty & gnt_en;
    endtask

    task automatic upstream_update(input logic [N_IN-1:0] taken);
        logic [PKT_W-1:0] p;
        cap_now = 1'b0;
        for (int i = 0; i < N_IN; i++) begin
            if (taken[i] && up_q[i].size() > 0) begin
                p = up_q[i].pop_front();
                in_packet[i*PKT_W +: PKT_W] = p;
                sb.push_back({SEL_W'(i), p});
                order.push_back(i);
                cap_now = 1'b1;
            end
        end
        refresh();
    endtask

    task automatic tick();
        logic [N_IN-1:0]        taken;
        logic [SEL_W+PKT_W-1:0] e;
        #1;
        if (out_read_gnt) begin
            if (sb.size() == 0) check("sb_underflow", 64'd1, 64'd0);
            else begin
                e = sb.pop_front();
                check("pop_src", 64'(out_src), 64'(e[SEL_W+PKT_W-1:PKT_W]));
                check("pop_pkt", 64'(out_packet), 64'(e[PKT_W-1:0]));
            end
        end
        taken = in_read_gnt;
        @(posedge clk);
        @(negedge clk);
        upstream_update(taken);
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        out_read_req = 1'b0;
        for (int i = 0; i < N_IN; i++) up_q[i].delete();
        sb.delete();
        order.delete();
        gnt_en = '1;
        in_packet = '0;
        cap_now = 1'b0;
        @(negedge clk);
        refresh();
        @(negedge clk);
        rst = 1'b1;
        refresh();
    endtask

    task automatic drain(input int cycles);
        out_read_req = 1'b1;
        for (int n = 0; n < cycles; n++) tick();
        out_read_req = 1'b0;
        check("drain_sb_empty", 64'(sb.size()), 64'd0);
        check("drain_out_empty", 64'(out_empty), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t             vecs [4];
        int               exp_order [8];
        int               n;
        logic [PKT_W-1:0] p9 [5];

        vecs[0] = '{ch: 7,  pkt: 36'hABCDE1234, exp_req: 20'h00080};
        vecs[1] = '{ch: 0,  pkt: 36'h123456789, exp_req: 20'h00001};
        vecs[2] = '{ch: 19, pkt: 36'hFFFFFFFFF, exp_req: 20'h80000};
        vecs[3] = '{ch: 12, pkt: 36'h000000001, exp_req: 20'h01000};
`ifdef MERGE_RR_EN
        exp_order = '{0, 3, 19, 0, 3, 19, 0, 0};
`else
        exp_order = '{0, 0, 0, 0, 3, 3, 19, 19};
`endif

        // Reset values, with a pop request held during reset
        rst = 1'b0;
        out_read_req = 1'b1;
        in_empty = '1;
        in_read_gnt = '0;
        in_packet = '0;
        gnt_en = '1;
        #3;
        check("rst_req", 64'(in_read_req), 64'd0);
        check("rst_empty", 64'(out_empty), 64'd1);
        check("rst_full", 64'(out_full), 64'd0);
        check("rst_count", 64'(out_count), 64'd0);
        check("rst_packet", 64'(out_packet), 64'd0);
        check("rst_src", 64'(out_src), 64'd0);
        check("rst_gnt", 64'(out_read_gnt), 64'd0);
        apply_reset();

        // Single-channel transactions from the vector table
        for (int v = 0; v < 4; v++) begin
            up_q[vecs[v].ch].push_back(vecs[v].pkt);
            refresh();
            check("tbl_idle_req", 64'(in_read_req), 64'd0);
            tick();
            check("tbl_req", 64'(in_read_req), 64'(vecs[v].exp_req));
            tick();
            check("tbl_cap_req", 64'(in_read_req), 64'd0);
            check("tbl_cap_count", 64'(out_count), 64'd0);
            tick();
            check("tbl_packet", 64'(out_packet), 64'(vecs[v].pkt));
            check("tbl_src", 64'(out_src), 64'(vecs[v].ch));
            check("tbl_count", 64'(out_count), 64'd1);
            out_read_req = 1'b1;
            tick();
            out_read_req = 1'b0;
            check("tbl_popped_empty", 64'(out_empty), 64'd1);
        end
        out_read_req = 1'b1;
        #1;
        check("empty_pop_gnt", 64'(out_read_gnt), 64'd0);
        check("empty_pop_packet_hold", 64'(out_packet), 64'(vecs[3].pkt));
        out_read_req = 1'b0;

        // Asynchronous reset while a request is outstanding
        apply_reset();
        up_q[1].push_back(36'h111111111);
        refresh();
        for (int k = 0; k < 4; k++) tick();
        check("mid_pre_count", 64'(out_count), 64'd1);
        up_q[2].push_back(36'h222222222);
        gnt_en[2] = 1'b0;
        refresh();
        tick();
        check("mid_req", 64'(in_read_req), 64'h00004);
        tick();
        check("mid_req_hold", 64'(in_read_req), 64'h00004);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_req", 64'(in_read_req), 64'd0);
        check("mid_rst_empty", 64'(out_empty), 64'd1);
        check("mid_rst_count", 64'(out_count), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        sb.delete();
        gnt_en = '1;
        refresh();
        tick();
        check("mid_restart_req", 64'(in_read_req), 64'h00004);
        drain(10);

        // Arbitration order with three persistently busy channels
        apply_reset();
        for (int k = 0; k < 4; k++) up_q[0].push_back(36'h000000A00 + 36'(k));
        for (int k = 0; k < 2; k++) up_q[3].push_back(36'h000003A00 + 36'(k));
        for (int k = 0; k < 2; k++) up_q[19].push_back(36'h000019A00 + 36'(k));
        refresh();
        n = 0;
        while (order.size() < 8 && n < 60) begin
            tick();
            n++;
        end
        check("fair_captures", 64'(order.size()), 64'd8);
        for (int k = 0; k < 8 && k < order.size(); k++)
            check($sformatf("fair_order_%0d", k), 64'(order[k]), 64'(exp_order[k]));
        drain(30);

        // Backpressure: fill to DEPTH, then a single pop re-opens admission
        apply_reset();
        for (int k = 0; k < 17; k++) up_q[1].push_back(36'h100000000 + 36'(k));
        refresh();
        n = 0;
        while (out_count != CNT_W'(DEPTH) && n < 100) begin
            tick();
            n++;
        end
        check("bp_full", 64'(out_full), 64'd1);
        check("bp_count", 64'(out_count), 64'd16);
        for (int k = 0; k < 6; k++) begin
            tick();
            check("bp_no_req", 64'(in_read_req), 64'd0);
        end
        out_read_req = 1'b1;
        tick();
        out_read_req = 1'b0;
        check("bp_admit_req", 64'(in_read_req), 64'h00002);
        check("bp_count_after_pop", 64'(out_count), 64'd15);
        tick();
        tick();
        check("bp_refilled", 64'(out_count), 64'd16);
        drain(80);

        // Pop and capture in the same cycle at occupancy 4
        apply_reset();
        for (int k = 0; k < 5; k++) begin
            p9[k] = 36'h900000000 + 36'(k * 17);
            up_q[9].push_back(p9[k]);
        end
        refresh();
        n = 0;
        while (!(cap_now && out_count == 5'd4) && n < 60) begin
            tick();
            n++;
        end
        check("conc_cap_at_4", 64'(cap_now && out_count == 5'd4), 64'd1);
        out_read_req = 1'b1;
        tick();
        out_read_req = 1'b0;
        check("conc_count", 64'(out_count), 64'd4);
        check("conc_head_adv", 64'(out_packet), 64'(p9[1]));
        drain(10);

        // Abort: selected channel goes empty without a grant
        apply_reset();
        up_q[5].push_back(36'h555555555);
        up_q[6].push_back(36'h666666666);
        gnt_en[5] = 1'b0;
        refresh();
        tick();
        check("abort_req", 64'(in_read_req), 64'h00020);
        tick();
        check("abort_req_hold", 64'(in_read_req), 64'h00020);
        up_q[5].delete();
        refresh();
        tick();
        check("abort_cleared", 64'(in_read_req), 64'd0);
        check("abort_no_write", 64'(out_count), 64'd0);
        tick();
        check("abort_next_req", 64'(in_read_req), 64'h00040);
        drain(10);
        check("abort_captures", 64'(order.size()), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/noc_merge_arbiter.md
Name: noc_merge_arbiter

Overview:
Parametrised N-to-1 merge stage between the per-clause-group packet FIFOs and the shared PE input queue. It selects a non-empty upstream FIFO, reads one packet over that FIFO's read_req/read_gnt handshake, and buffers it in an internal first-word-fall-through queue. The queue is drained by the PEs through a FIFO-style read port. It adds round-robin fairness, backpressure, source tagging and abort handling.

Parameters:
N_IN, 20, number of upstream FIFO channels (2..32)
PKT_W, 36, packet width in bits
DEPTH, 16, internal queue depth in entries; must be a power of 2, at least 2
SEL_W, $clog2(N_IN), width of the channel index (derived; do not override)

Ports:
clk  in  1  clock; all state changes on the rising edge
rst  in  1  asynchronous reset, active-low: rst=0 clears all state immediately
in_empty  in  N_IN  upstream FIFO empty flags; bit i is channel i
in_packet  in  N_IN*PKT_W  upstream packet data; channel i occupies [i*PKT_W +: PKT_W]
in_read_req  out  N_IN  one-hot read request to the upstream FIFOs
in_read_gnt  in  N_IN  upstream read grant; bit i qualifies in_packet of channel i on the following cycle
out_read_req  in  1  PE-side pop request
out_read_gnt  out  1  pop accepted; combinational out_read_req & !out_empty
out_empty  out  1  queue empty
out_full  out  1  queue holds DEPTH entries
out_packet  out  PKT_W  head packet (FWFT); holds its last value when the queue is empty
out_src  out  SEL_W  source channel index of the head packet
out_count  out  $clog2(DEPTH)+1  queue occupancy

Behaviour:
- Reset values (rst=0): FSM=IDLE; in_read_req=0; queue pointers=0; out_count=0; out_empty=1; out_full=0; out_packet=0; out_src=0; round-robin pointer=0; out_read_gnt=0.
- A packet in flight when reset asserts is discarded. The upstream FIFO is not compensated.
- FSM states: IDLE, REQ, CAP.
- IDLE:
  - Leave IDLE only if at least one in_empty bit is 0 and out_count < DEPTH, evaluated after this cycle's pop.
  - Select a channel (rule below), register sel, set in_read_req = one-hot(sel) on the next edge, go to REQ.
  - Otherwise in_read_req stays 0.
- REQ: in_read_req is held.
  - in_read_gnt[sel]=1: clear in_read_req on the next edge and go to CAP.
  - in_read_gnt[sel]=0 and in_empty[sel]=1 (abort): clear in_read_req and return to IDLE. No write, RR pointer unchanged.
  - Grant bits of unselected channels are ignored.
- CAP: in_packet[sel] is valid this cycle. Write {sel, in_packet[sel]} to the queue tail, advance the RR pointer to (sel+1) mod N_IN, return to IDLE.
- Minimum ingress cost is 3 cycles per packet. Only one packet is ever in flight, so the admission check in IDLE guarantees that a CAP write never overflows.
- Queue:
  - Pop when out_read_gnt=1. The head advances on the edge.
  - A simultaneous CAP write and pop leaves out_count unchanged.
  - There is no bypass: a write into an empty queue becomes visible on out_packet the cycle after CAP.
  - A pop request while empty is ignored (out_read_gnt=0).
- Pointers wrap modulo DEPTH. out_count stays in the range 0..DEPTH.
- out_full = (out_count==DEPTH); out_empty = (out_count==0).

Optional Feature:
Macro MERGE_RR_EN.
- Defined: round-robin selection. The first non-empty channel is searched from the RR pointer upward, wrapping at N_IN-1 to 0.
- Undefined: fixed priority, lowest non-empty index wins. The RR pointer is not implemented and out_src is unchanged in meaning.
- Handshake, timing and queue behaviour are identical in both builds.

Test Plan:
- Reset mid-REQ: drive rst=0 for 1 cycle while in_read_req=0x00004 -> in_read_req=0, out_empty=1, out_count=0 immediately (asynchronous); the FSM restarts from IDLE.
- Single channel, N_IN=20: in_empty[7]=0, grant one cycle after request, packet 0xABCDE1234 -> in_read_req=0x00080 for exactly the REQ cycles; out_packet=0xABCDE1234, out_src=7, out_count=1 three cycles after leaving IDLE.
- Fairness: channels 0, 3 and 19 permanently non-empty -> capture order 0,3,19,0,3,19 with MERGE_RR_EN defined; 0,0,0,0 without it.
- Backpressure, DEPTH=16: fill with out_read_req=0 -> out_full=1 and out_count=16, in_read_req stays 0; one pop -> next admission begins, out_count returns to 16.
- Abort: channel 5 requested, no grant, in_empty[5] rises -> in_read_req cleared next edge; no write; next request goes to the next non-empty channel.
- Concurrent pop and capture at out_count=4 -> out_count stays 4, the head advances, and the captured packet appears at the correct tail position.
